uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Upstream boot stage for the 8-bit accumulator core.
- Receives a program image over a UART RX line and feeds it byte by byte into the core's manual loader interface (loader_en / load / load_in).
- Then pulses the core's reset so its PC returns to 0, and asserts run.
- Optional bypass boots straight to run with no load.

Parameters:
- CLKS_PER_BIT, 104, clk_i cycles per UART bit; minimum 4.
- PROG_LEN, 64, bytes per image; range 1..64.
- RST_CYCLES, 4, length of each core reset pulse in clk_i cycles; minimum 1.

Ports:
- clk_i, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- rx_i, input, 1, UART RX; asynchronous, idle high.
- skip_load, input, 1, sampled when the reset pulse ends; 1 skips LOAD.
- cpu_rst_n, output, 1, active-low reset to the core; registered.
- loader_en, output, 1, core loader enable.
- load, output, 1, core load strobe; one-cycle pulse per byte.
- load_in, output, 8, byte presented to the core.
- run, output, 1, core run enable.
- loading, output, 1, high while in LOAD.
- frame_err, output, 1, sticky framing-error flag.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n is asynchronous and active-low.
- Reset values: cpu_rst_n=0, loader_en=0, load=0, load_in=0, run=0, loading=0, frame_err=0, state=CPURST, byte_cnt=0.
- RX front end:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge in idle starts a frame. Input is re-sampled at CLKS_PER_BIT/2; if it is high there, it was a glitch: return to idle.
  - The 8 data bits are sampled at bit centres, LSB first.
  - Stop bit sampled high: rx_valid pulses one cycle with the byte.
  - Stop bit sampled low: byte dropped, frame_err set. frame_err is cleared only by rst_n.
- Main FSM:
  - CPURST: cpu_rst_n=0 and all other outputs 0, held for RST_CYCLES cycles. On exit, skip_load=0 goes to LOAD, skip_load=1 goes to RUN.
  - LOAD: cpu_rst_n=1, loader_en=1, loading=1. On rx_valid: load_in<=byte and load=1 for exactly one cycle; byte_cnt increments. When the pulse for byte PROG_LEN-1 completes (load returns to 0), go to RESTART.
  - RESTART: loader_en=0, cpu_rst_n=0 for RST_CYCLES cycles, then go to RUN. This is required because the core's PC sits at PROG_LEN after loading.
  - RUN: cpu_rst_n=1 and run=1 are asserted in the same cycle; terminal state. Received bytes are ignored.
- Handshake guarantee: a load high pulse is always followed by at least one low cycle before the next pulse, since bytes are at least 10*CLKS_PER_BIT apart. The core's edge detector therefore sees every byte.
- load_in holds its last value and changes only on rx_valid in LOAD.
- Simultaneous events: rx_valid in any state other than LOAD is discarded. A frame in progress when the FSM leaves LOAD is discarded.
- Reset mid-load: everything returns to CPURST and byte_cnt=0. The image must be resent in full.
- byte_cnt width is $clog2(PROG_LEN+1). It never wraps, because LOAD exits at PROG_LEN.

Optional Feature:
- Macro: UART_BREAK_RELOAD_EN.
- Defined: in RUN or LOAD, the synchronized rx_i held low for at least 2*10*CLKS_PER_BIT consecutive cycles (a break) forces CPURST with skip_load treated as 0 and byte_cnt=0. Loading restarts after rx_i returns high; any frame error seen during the break is not flagged.
- Not defined: break is treated as ordinary framing (frame_err sets); RUN stays terminal until rst_n.

Decomposition:
- Package uart_prog_pkg:
  - state enum {CPURST, LOAD, RESTART, RUN};
  - RX bit-phase constants;
  - a function computing counter widths from CLKS_PER_BIT.
- Sub-module uart_rx_byte: synchronizer, bit timer, shift register, rx_valid/frame_err outputs. The loader FSM stays in the top module.

Test Plan:
1. CLKS_PER_BIT=8, PROG_LEN=4, skip_load=0; send 0x11,0x22,0x33,0x44 → four single-cycle load pulses with load_in matching each byte. Then cpu_rst_n low for 4 cycles with loader_en=0, then run=1 and cpu_rst_n=1 together. frame_err=0.
2. skip_load=1 after reset → loader_en never asserts; run=1 exactly RST_CYCLES cycles after rst_n release, with no load pulse.
3. Byte 0x5A sent with stop bit low → no load pulse, frame_err=1, byte_cnt unchanged. Next valid byte 0x01 loads normally and frame_err stays 1.
4. 1-bit-time/3 low glitch on rx_i in LOAD → no rx_valid, no load pulse, no frame_err.
5. rst_n asserted after 2 of 4 bytes → all outputs at reset values asynchronously. The 4 bytes are then resent, the full sequence completes, and exactly 4 load pulses occur after the reset.
6. UART_BREAK_RELOAD_EN defined; in RUN, hold rx_i low 170 cycles (CLKS_PER_BIT=8) → run drops to 0 and the FSM goes CPURST then LOAD. A new 4-byte image loads and run reasserts. Macro undefined: same stimulus → run stays 1 and frame_err=1.

Source files
------------

// File: rtl/uart_prog_pkg.sv
// Shared types and sizing helpers for the UART program loader and its RX front end.
package uart_prog_pkg;

    typedef enum logic [1:0] {CPURST, LOAD, RESTART, RUN} state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_phase_t;

    localparam int RX_DATA_BITS = 8;

    // Width of a counter that must hold values up to clks.
    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks + 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: 2-flop sync, start-bit glitch rejection, LSB-first capture, sticky frame_err.
// With UART_BREAK_RELOAD_EN it also flags a line break and suppresses frame errors caused by it.
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       brk_hit
);
    localparam int TW = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_phase_t     phase;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          ferr_evt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            phase    <= RX_IDLE;
            tmr      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            ferr_evt <= 1'b0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            ferr_evt <= 1'b0;
            case (phase)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        phase <= RX_START;
                        tmr   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid start bit means it was only a glitch.
                    if (tmr == HALF) begin
                        tmr     <= '0;
                        bit_idx <= '0;
                        phase   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (tmr == FULL) begin
                        tmr     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(RX_DATA_BITS - 1)) phase <= RX_STOP;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (tmr == FULL) begin
                        tmr   <= '0;
                        phase <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                        end else begin
                            ferr_evt <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: phase <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_BREAK_RELOAD_EN
    localparam int BRK_N = 20 * CLKS_PER_BIT;
    localparam int BKW   = cnt_width(BRK_N);

    logic [BKW-1:0] brk_cnt;
    logic           brk_seen, ferr_pend;

    // A frame error is only committed once the line goes idle, so a break can still veto it.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            brk_cnt   <= '0;
            brk_seen  <= 1'b0;
            ferr_pend <= 1'b0;
            brk_hit   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            brk_hit <= 1'b0;
            if (rx_sync) begin
                brk_cnt   <= '0;
                brk_seen  <= 1'b0;
                ferr_pend <= 1'b0;
                if ((ferr_pend || ferr_evt) && !brk_seen) frame_err <= 1'b1;
            end else begin
                ferr_pend <= ferr_pend | ferr_evt;
                if (brk_cnt != BKW'(BRK_N)) brk_cnt <= brk_cnt + BKW'(1);
                if (brk_cnt == BKW'(BRK_N - 1)) begin
                    brk_seen <= 1'b1;
                    brk_hit  <= 1'b1;
                end
            end
        end
    end
`else
    assign brk_hit = 1'b0;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= frame_err | ferr_evt;
    end
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Boot stage: streams a UART image into the core's loader port, re-resets the core, then runs it.
// Building with UART_BREAK_RELOAD_EN lets a line break in LOAD or RUN force a fresh load.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int PROG_LEN     = 64,
    parameter int RST_CYCLES   = 4
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       skip_load,
    output logic       cpu_rst_n,
    output logic       loader_en,
    output logic       load,
    output logic [7:0] load_in,
    output logic       run,
    output logic       loading,
    output logic       frame_err
);
    localparam int BW = $clog2(PROG_LEN + 1);
    localparam int RW = cnt_width(RST_CYCLES);

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [RW-1:0] rst_cnt;
    logic          force_load;
    logic          rx_valid, brk_hit;
    logic [7:0]    rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .rx_i     (rx_i),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .brk_hit  (brk_hit)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CPURST;
            cpu_rst_n  <= 1'b0;
            loader_en  <= 1'b0;
            load       <= 1'b0;
            load_in    <= '0;
            run        <= 1'b0;
            loading    <= 1'b0;
            byte_cnt   <= '0;
            rst_cnt    <= '0;
            force_load <= 1'b0;
        end else if (brk_hit && (state == LOAD || state == RUN)) begin
            state      <= CPURST;
            cpu_rst_n  <= 1'b0;
            loader_en  <= 1'b0;
            load       <= 1'b0;
            run        <= 1'b0;
            loading    <= 1'b0;
            byte_cnt   <= '0;
            rst_cnt    <= '0;
            force_load <= 1'b1;
        end else begin
            case (state)
                CPURST: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        rst_cnt    <= '0;
                        cpu_rst_n  <= 1'b1;
                        force_load <= 1'b0;
                        if (skip_load && !force_load) begin
                            state <= RUN;
                            run   <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            loader_en <= 1'b1;
                            loading   <= 1'b1;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                LOAD: begin
                    load <= 1'b0;
                    // Leave only after the last strobe has been seen low again by the core.
                    if (load && byte_cnt == BW'(PROG_LEN)) begin
                        state     <= RESTART;
                        loader_en <= 1'b0;
                        loading   <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end else if (rx_valid) begin
                        load     <= 1'b1;
                        load_in  <= rx_data;
                        byte_cnt <= byte_cnt + BW'(1);
                    end
                end
                RESTART: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        rst_cnt   <= '0;
                        state     <= RUN;
                        cpu_rst_n <= 1'b1;
                        run       <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                RUN: ;
                default: state <= CPURST;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: byte scoreboard plus per-cycle protocol checks.
module tb_uart_prog_loader;
    localparam int CPB = 8;
    localparam int PL  = 4;
    localparam int RC  = 4;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       skip_load = 1'b0;
    logic       cpu_rst_n, loader_en, load, run, loading, frame_err;
    logic [7:0] load_in;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .PROG_LEN(PL), .RST_CYCLES(RC)) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .rx_i     (rx_i),
        .skip_load(skip_load),
        .cpu_rst_n(cpu_rst_n),
        .loader_en(loader_en),
        .load     (load),
        .load_in  (load_in),
        .run      (run),
        .loading  (loading),
        .frame_err(frame_err)
    );

    always #5 clk_i = ~clk_i;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_mem [256];
    int         exp_wr = 0, exp_rd = 0;
    int         n_pulses = 0, low_len = 0, last_low_len = 0;
    logic       rise_run = 1'b0, saw_en = 1'b0;
    logic       p_load = 1'b0, p_rst = 1'b0;
    logic [7:0] p_load_in = 8'h00;
    logic       m_in_load = 1'b0;
    int         m_acc = 0;
    int         base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle comparison against the byte scoreboard and the loader protocol rules.
    task automatic monitor();
        if (!rst_n) begin
            n_pulses = 0; low_len = 0; exp_rd = exp_wr;
            p_load = 1'b0; p_load_in = 8'h00; p_rst = 1'b0; saw_en = 1'b0;
            return;
        end
        if (load) begin
            chk("load_gap", 32'(p_load), 0);
            chk("load_ctx", {29'd0, loader_en, cpu_rst_n, run}, 32'b110);
            chk("load_expected", 32'(exp_wr > exp_rd), 1);
            if (exp_wr > exp_rd) begin
                chk("load_byte", 32'(load_in), 32'(exp_mem[exp_rd % 256]));
                exp_rd++;
            end
            n_pulses++;
        end else begin
            chk("load_in_hold", 32'(load_in), 32'(p_load_in));
        end
        chk("loading_vs_en", 32'(loading), 32'(loader_en));
        if (run) chk("run_ctx", {30'd0, cpu_rst_n, loader_en}, 32'b10);
        if (loader_en) saw_en = 1'b1;
        if (!cpu_rst_n) low_len++;
        else if (!p_rst) begin
            last_low_len = low_len;
            low_len = 0;
            rise_run = run;
        end
        p_load = load; p_load_in = load_in; p_rst = cpu_rst_n;
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx_i = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_cycles(CPB);
        end
        if (stop_ok && m_in_load) begin
            exp_mem[exp_wr % 256] = b;
            exp_wr++;
            m_acc++;
            if (m_acc == PL) m_in_load = 1'b0;
        end
        rx_i = stop_ok;
        wait_cycles(CPB);
        rx_i = 1'b1;
        wait_cycles(2 * CPB);
    endtask

    task automatic do_reset(input logic skip);
        rst_n = 1'b0;
        rx_i = 1'b1;
        skip_load = skip;
        #1;
        chk("reset_vals", {17'd0, cpu_rst_n, loader_en, load, load_in, run, loading, frame_err}, 0);
        step();
        rst_n = 1'b1;
        m_in_load = !skip;
        m_acc = 0;
    endtask

    initial begin
        // 1: full image load, restart pulse, run
        do_reset(1'b0);
        wait_cycles(RC + 2);
        chk("t1_boot_rst_len", 32'(last_low_len), RC);
        chk("t1_boot_no_run", 32'(rise_run), 0);
        chk("t1_in_load", {29'd0, loader_en, loading, cpu_rst_n}, 32'b111);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("t1_pulses", 32'(n_pulses), 4);
        chk("t1_restart_len", 32'(last_low_len), RC);
        chk("t1_run_with_rst", 32'(rise_run), 1);
        chk("t1_run_state", {29'd0, run, cpu_rst_n, loader_en}, 32'b110);
        chk("t1_load_in_last", 32'(load_in), 32'h44);
        chk("t1_frame_err", 32'(frame_err), 0);

        // 2: skip_load boots straight to run
        do_reset(1'b1);
        wait_cycles(RC - 1);
        chk("t2_run_early", 32'(run), 0);
        step();
        chk("t2_run_on_time", {30'd0, run, cpu_rst_n}, 32'b11);
        send_byte(8'h77, 1'b1);
        chk("t2_no_pulses", 32'(n_pulses), 0);
        chk("t2_no_loader_en", 32'(saw_en), 0);

        // 3: bad stop bit, then a good byte
        do_reset(1'b0);
        wait_cycles(RC + 2);
        send_byte(8'h5A, 1'b0);
        chk("t3_ferr_set", 32'(frame_err), 1);
        chk("t3_no_pulse", 32'(n_pulses), 0);
        send_byte(8'h01, 1'b1);
        chk("t3_good_pulse", 32'(n_pulses), 1);
        chk("t3_load_in", 32'(load_in), 32'h01);
        chk("t3_ferr_sticky", 32'(frame_err), 1);

        // 4: short glitch is rejected
        do_reset(1'b0);
        wait_cycles(RC + 2);
        rx_i = 1'b0;
        wait_cycles(CPB / 3);
        rx_i = 1'b1;
        wait_cycles(12 * CPB);
        chk("t4_no_pulse", 32'(n_pulses), 0);
        chk("t4_no_ferr", 32'(frame_err), 0);
        chk("t4_still_load", 32'(loader_en), 1);

        // 5: reset mid-load, then full resend
        do_reset(1'b0);
        wait_cycles(RC + 2);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        chk("t5_two_pulses", 32'(n_pulses), 2);
        do_reset(1'b0);
        wait_cycles(RC + 2);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        chk("t5_four_pulses", 32'(n_pulses), 4);
        chk("t5_run", {30'd0, run, cpu_rst_n}, 32'b11);

        // 6: long low on rx while running
        base = n_pulses;
        rx_i = 1'b0;
        wait_cycles(170);
        rx_i = 1'b1;
        wait_cycles(6);
`ifdef UART_BREAK_RELOAD_EN
        chk("t6_run_dropped", 32'(run), 0);
        chk("t6_reloading", {29'd0, loader_en, loading, cpu_rst_n}, 32'b111);
        chk("t6_no_ferr", 32'(frame_err), 0);
        m_in_load = 1'b1;
        m_acc = 0;
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        chk("t6_reload_pulses", 32'(n_pulses - base), 4);
        chk("t6_run_again", {30'd0, run, cpu_rst_n}, 32'b11);
        chk("t6_restart_len", 32'(last_low_len), RC);
`else
        chk("t6_run_kept", 32'(run), 1);
        chk("t6_ferr", 32'(frame_err), 1);
        chk("t6_no_loader", 32'(loader_en), 0);
        chk("t6_no_pulses", 32'(n_pulses - base), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
